// File: rtl/ghost_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ghost_pkg
// Description : Shared types and constants for the SD/cipher block scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package ghost_pkg;

    localparam int TIMEOUT_W_DEF = 24;
    localparam int BLK_W_DEF     = 23;

    localparam logic RAM_SEL_SD   = 1'b0;
    localparam logic RAM_SEL_CIPH = 1'b1;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_INIT    = 4'd1,
        ST_RD_REQ  = 4'd2,
        ST_RD_WAIT = 4'd3,
        ST_CIPH    = 4'd4,
        ST_WR      = 4'd5,
        ST_WR_GAP  = 4'd6,
        ST_DONE    = 4'd7,
        ST_FAIL    = 4'd8
    } state_t;

    function automatic logic is_busy(input state_t s);
        return !((s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAIL));
    endfunction

    // RD_REQ is a single-cycle state, so it never needs watching.
    function automatic logic wd_counts(input state_t s);
        return (s == ST_INIT) || (s == ST_RD_WAIT) || (s == ST_CIPH) ||
               (s == ST_WR)   || (s == ST_WR_GAP);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ghost_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : ghost_sched_if
// Description : Handshake bundle between the scheduler and the board/SD/cipher.
// Revision    : 1.0 - initial release
// ============================================================================
interface ghost_sched_if
    import ghost_pkg::*;
#(
    parameter int BLK_W = BLK_W_DEF
);
    logic             istart;
    logic             osd_start;
    logic             isd_ready;
    logic             oread;
    logic             irx_done;
    logic             owrite;
    logic             itx_done;
    logic             isd_success;
    logic             isd_fail;
    logic             ocipher_start;
    logic             icipher_done;
    logic             oram_sel;
    logic             obusy;
    logic             odone;
    logic             ofail;
    logic [BLK_W-1:0] oblocks;

    modport master (
        input  istart, isd_ready, irx_done, itx_done, isd_success, isd_fail,
               icipher_done,
        output osd_start, oread, owrite, ocipher_start, oram_sel, obusy,
               odone, ofail, oblocks
    );

    modport slave (
        output istart, isd_ready, irx_done, itx_done, isd_success, isd_fail,
               icipher_done,
        input  osd_start, oread, owrite, ocipher_start, oram_sel, obusy,
               odone, ofail, oblocks
    );
endinterface
`default_nettype wire

// File: rtl/ghost_sched_watchdog.sv
`default_nettype none
// ============================================================================
// Module      : sched_watchdog
// Description : Saturating per-state watchdog with registered timeout flag.
// Revision    : 1.0 - initial release
// ============================================================================
module sched_watchdog
    import ghost_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF
) (
    input  wire logic clk_i,
    input  wire logic rst_i,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      timeout_o
);
    logic [TIMEOUT_W-1:0] cnt_q, cnt_d;
    logic                 timeout_q, timeout_d;

    // Flag rises on the same edge the count lands on all-ones.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        if (clr_i) begin
            cnt_d     = '0;
            timeout_d = 1'b0;
        end else if (en_i) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + TIMEOUT_W'(1);
            end
            timeout_d = (cnt_d == '1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    assign timeout_o = timeout_q;
endmodule
`default_nettype wire

// File: rtl/ghost_sched.sv
`default_nettype none
// ============================================================================
// Module      : ghost_sched
// Description : Sequences SD read, cipher and SD write over one shared RAM.
// Revision    : 1.0 - initial release
// ============================================================================
module ghost_sched
    import ghost_pkg::*;
#(
    parameter int TIMEOUT_W = TIMEOUT_W_DEF,
    parameter int BLK_W     = BLK_W_DEF
) (
    input  wire logic     iclk,
    input  wire logic     irst,
    ghost_sched_if.master bus
);
    state_t           state_q, state_d;
    logic [BLK_W-1:0] blocks_q, blocks_d;
    logic             sd_start_q, sd_start_d;
    logic             read_q, read_d;
    logic             write_q, write_d;
    logic             ciph_start_q, ciph_start_d;
    logic             ram_sel_q, ram_sel_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic             w_wd_clr;
    logic             w_wd_en;
    logic             w_wd_timeout;
    logic             w_abort;

    sched_watchdog #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_wd (
        .clk_i     (iclk),
        .rst_i     (irst),
        .clr_i     (w_wd_clr),
        .en_i      (w_wd_en),
        .timeout_o (w_wd_timeout)
    );

    assign w_wd_clr = (state_d != state_q);
    assign w_wd_en  = wd_counts(state_q);

    // Failure overrides every done pulse arriving in the same cycle.
    assign w_abort = is_busy(state_q) &&
                     (bus.isd_fail || w_wd_timeout ||
                      (bus.isd_success && (state_q != ST_INIT) &&
                       (state_q != ST_RD_WAIT)));

    always_comb begin
        state_d  = state_q;
        blocks_d = blocks_q;
        unique case (state_q)
            ST_IDLE, ST_DONE, ST_FAIL: begin
                if (bus.istart) begin
                    state_d  = ST_INIT;
                    blocks_d = '0;
                end
            end
            ST_INIT: begin
                if (bus.isd_ready) state_d = ST_RD_REQ;
            end
            ST_RD_REQ: begin
                state_d = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                if (bus.isd_success)   state_d = ST_DONE;
                else if (bus.irx_done) state_d = ST_CIPH;
            end
            ST_CIPH: begin
                if (bus.icipher_done) state_d = ST_WR;
            end
            ST_WR: begin
                if (bus.itx_done) begin
                    state_d  = ST_WR_GAP;
                    blocks_d = blocks_q + BLK_W'(1);
                end
            end
            ST_WR_GAP: begin
                if (bus.isd_ready) state_d = ST_RD_REQ;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_abort) begin
            state_d  = ST_FAIL;
            blocks_d = blocks_q;
        end
    end

    // Outputs are decoded from the next state so they align with state_q.
    always_comb begin
        sd_start_d   = !is_busy(state_q) && bus.istart;
        read_d       = (state_d == ST_RD_REQ);
        write_d      = (state_d == ST_WR);
        ciph_start_d = (state_d == ST_CIPH) && (state_q != ST_CIPH);
        ram_sel_d    = (state_d == ST_CIPH) ? RAM_SEL_CIPH : RAM_SEL_SD;
        busy_d       = is_busy(state_d);
        done_d       = (state_d == ST_DONE);
        fail_d       = (state_d == ST_FAIL);
    end

    always_ff @(posedge iclk) begin
        if (irst) begin
            state_q      <= ST_IDLE;
            blocks_q     <= '0;
            sd_start_q   <= 1'b0;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            ciph_start_q <= 1'b0;
            ram_sel_q    <= RAM_SEL_SD;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            blocks_q     <= blocks_d;
            sd_start_q   <= sd_start_d;
            read_q       <= read_d;
            write_q      <= write_d;
            ciph_start_q <= ciph_start_d;
            ram_sel_q    <= ram_sel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    assign bus.osd_start     = sd_start_q;
    assign bus.oread         = read_q;
    assign bus.owrite        = write_q;
    assign bus.ocipher_start = ciph_start_q;
    assign bus.oram_sel      = ram_sel_q;
    assign bus.obusy         = busy_q;
    assign bus.odone         = done_q;
    assign bus.ofail         = fail_q;
    assign bus.oblocks       = blocks_q;
endmodule
`default_nettype wire
